// File: rtl/fetch_queue.sv
// fetch_queue: instruction buffer between Fetch and Decode.
// Circular buffer of {pc, instr} pairs with a valid/ready head, a freeze
// output back to Fetch when full, and a flush that empties the queue on a
// taken branch. All outputs come from registered state only.
module fetch_queue #(
    parameter int DATA_WIDTH = 27,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Valid,
    input  logic [DATA_WIDTH-1:0] i_Pc,
    input  logic [DATA_WIDTH-1:0] i_Instruction,
    output logic                  o_Freeze,
    input  logic                  i_Flush,
    output logic                  o_Valid,
    output logic [DATA_WIDTH-1:0] o_Pc,
    output logic [DATA_WIDTH-1:0] o_Instruction,
    input  logic                  i_Ready,
    output logic [PTR_W:0]        o_Count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  push;
    logic                  pop;

    assign o_Valid  = (count != '0);
    assign o_Freeze = (count == FULL_CNT);
    assign o_Count  = count;

    // The head is masked to zero when empty so stale storage never leaks out.
    assign o_Pc          = o_Valid ? pc_mem[rd_ptr]    : '0;
    assign o_Instruction = o_Valid ? instr_mem[rd_ptr] : '0;

    // Flush wins over both sides of the handshake.
    assign push = i_Valid & ~o_Freeze & ~i_Flush;
    assign pop  = o_Valid & i_Ready  & ~i_Flush;

    // Storage write; contents are don't-care until covered by count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= i_Pc;
            instr_mem[wr_ptr] <= i_Instruction;
        end
    end

    // Pointer and occupancy tracking with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed bench for fetch_queue against a
// queue-based reference model.
module tb_fetch_queue;

    localparam int DW    = 27;
    localparam int DEPTH = 4;
    localparam int PW    = $clog2(DEPTH);

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] instr;
    } entry_t;

    logic          clk;
    logic          reset;
    logic          i_Valid;
    logic [DW-1:0] i_Pc;
    logic [DW-1:0] i_Instruction;
    logic          o_Freeze;
    logic          i_Flush;
    logic          o_Valid;
    logic [DW-1:0] o_Pc;
    logic [DW-1:0] o_Instruction;
    logic          i_Ready;
    logic [PW:0]   o_Count;

    entry_t        mq[$];
    logic [DW-1:0] seen[$];
    bit            last_push;
    int            n_checks;
    int            n_errors;

    fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_Valid       (i_Valid),
        .i_Pc          (i_Pc),
        .i_Instruction (i_Instruction),
        .o_Freeze      (o_Freeze),
        .i_Flush       (i_Flush),
        .o_Valid       (o_Valid),
        .o_Pc          (o_Pc),
        .o_Instruction (o_Instruction),
        .i_Ready       (i_Ready),
        .o_Count       (o_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock: log what Decode takes, update the model, settle.
    task automatic tick();
        bit     do_push;
        bit     do_pop;
        entry_t e;
        if (o_Valid && i_Ready && !i_Flush) seen.push_back(o_Pc);
        do_push = i_Valid && (mq.size() != DEPTH) && !i_Flush;
        do_pop  = (mq.size() != 0) && i_Ready && !i_Flush;
        e.pc    = i_Pc;
        e.instr = i_Instruction;
        @(posedge clk);
        if (i_Flush) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        last_push = do_push;
        #1;
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] pc, input logic [DW-1:0] ins,
                         input bit rdy, input bit fl);
        i_Valid       = v;
        i_Pc          = pc;
        i_Instruction = ins;
        i_Ready       = rdy;
        i_Flush       = fl;
    endtask

    task automatic test_reset();
        drive(0, '0, '0, 0, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (o_Valid !== 1'b0 || o_Freeze !== 1'b0 || o_Count !== '0 || o_Pc !== '0 || o_Instruction !== '0) begin
            n_errors++;
            $display("FAIL reset_state: valid=%b freeze=%b count=%0d pc=%h instr=%h, want all 0",
                     o_Valid, o_Freeze, o_Count, o_Pc, o_Instruction);
        end
        reset = 1'b1;
        mq.delete();
        #2;
    endtask

    task automatic test_reset_mid();
        drive(1, 27'd7, 27'h107, 0, 0); tick();
        drive(1, 27'd8, 27'h108, 0, 0); tick();
        n_checks++;
        if (o_Count !== 3'd2) begin
            n_errors++;
            $display("FAIL reset_mid_prefill: count=%0d want 2", o_Count);
        end
        drive(0, '0, '0, 0, 0);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (o_Valid !== 1'b0 || o_Count !== '0 || o_Pc !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_async: valid=%b count=%0d pc=%h want 0/0/0", o_Valid, o_Count, o_Pc);
        end
        reset = 1'b1;
        mq.delete();
        drive(1, 27'd10, 27'h110, 0, 0); tick();
        n_checks++;
        if (o_Pc !== 27'd10 || o_Count !== 3'd1 || o_Valid !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_resume: pc=%0d count=%0d valid=%b want 10/1/1", o_Pc, o_Count, o_Valid);
        end
        drive(0, '0, '0, 1, 0); tick();
        drive(0, '0, '0, 0, 0);
        seen.delete();
    endtask

    task automatic test_fill_full();
        for (int p = 1; p <= 4; p++) begin
            drive(1, DW'(p), DW'(32'h100 + p), 0, 0);
            tick();
        end
        n_checks++;
        if (o_Count !== 3'd4 || o_Freeze !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_full: count=%0d freeze=%b want 4/1", o_Count, o_Freeze);
        end
        drive(1, 27'd5, 27'h105, 0, 0); tick();
        n_checks++;
        if (o_Count !== 3'd4 || o_Pc !== 27'd1 || o_Instruction !== 27'h101) begin
            n_errors++;
            $display("FAIL full_ignore: count=%0d pc=%0d instr=%h want 4/1/101", o_Count, o_Pc, o_Instruction);
        end
    endtask

    task automatic test_drain_wrap();
        int next_pc;
        int budget;
        next_pc = 5;
        budget  = 0;
        while (seen.size() < 12 && budget < 60) begin
            drive(next_pc <= 12, DW'(next_pc), DW'(32'h100 + next_pc), 1, 0);
            tick();
            if (last_push) next_pc++;
            budget++;
        end
        n_checks++;
        if (seen.size() != 12) begin
            n_errors++;
            $display("FAIL drain_budget: drained=%0d want 12", seen.size());
        end
        for (int k = 0; k < 12 && k < seen.size(); k++) begin
            n_checks++;
            if (seen[k] !== DW'(k + 1)) begin
                n_errors++;
                $display("FAIL drain_order[%0d]: pc=%0d want %0d", k, seen[k], k + 1);
            end
        end
        drive(0, '0, '0, 0, 0);
        seen.delete();
    endtask

    task automatic test_push_pop();
        drive(1, 27'h11, 27'h211, 0, 0); tick();
        drive(1, 27'h12, 27'h212, 0, 0); tick();
        drive(1, 27'd20, 27'h220, 1, 0); tick();
        n_checks++;
        if (o_Count !== 3'd2 || o_Pc !== 27'h12) begin
            n_errors++;
            $display("FAIL push_pop: count=%0d pc=%h want 2/12", o_Count, o_Pc);
        end
        drive(0, '0, '0, 1, 0); tick();
        n_checks++;
        if (o_Pc !== 27'd20 || o_Instruction !== 27'h220) begin
            n_errors++;
            $display("FAIL push_pop_tail: pc=%h instr=%h want 14/220", o_Pc, o_Instruction);
        end
        tick();
        drive(0, '0, '0, 0, 0);
        seen.delete();
    endtask

    task automatic test_flush_full();
        for (int p = 0; p < 4; p++) begin
            drive(1, DW'(32'h30 + p), DW'(32'h330 + p), 0, 0);
            tick();
        end
        drive(1, 27'h99, 27'h399, 1, 1); tick();
        n_checks++;
        if (o_Count !== '0 || o_Valid !== 1'b0 || o_Freeze !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_full: count=%0d valid=%b freeze=%b want 0/0/0", o_Count, o_Valid, o_Freeze);
        end
        drive(1, 27'h40, 27'h440, 1, 0); tick();
        n_checks++;
        if (o_Valid !== 1'b1 || o_Pc !== 27'h40 || o_Instruction !== 27'h440) begin
            n_errors++;
            $display("FAIL flush_resume: valid=%b pc=%h instr=%h want 1/40/440", o_Valid, o_Pc, o_Instruction);
        end
        drive(0, '0, '0, 1, 0); tick();
        n_checks++;
        if (seen.size() != 1 || seen[0] !== 27'h40) begin
            n_errors++;
            $display("FAIL flush_leak: drained=%0d first=%h want 1 entry 40", seen.size(),
                     seen.size() ? seen[0] : '0);
        end
        drive(0, '0, '0, 0, 0);
        seen.delete();
    endtask

    task automatic test_back_to_back_flush();
        for (int k = 0; k < 3; k++) begin
            drive(1, DW'(32'h50 + k), 27'h0, 1, 1);
            tick();
            n_checks++;
            if (o_Count !== '0 || o_Valid !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b_flush[%0d]: count=%0d valid=%b want 0/0", k, o_Count, o_Valid);
            end
        end
        drive(1, 27'h5a, 27'h45a, 0, 0); tick();
        n_checks++;
        if (o_Count !== 3'd1 || o_Pc !== 27'h5a) begin
            n_errors++;
            $display("FAIL b2b_resume: count=%0d pc=%h want 1/5a", o_Count, o_Pc);
        end
        drive(0, '0, '0, 1, 0); tick();
        drive(0, '0, '0, 0, 0);
        seen.delete();
    endtask

    task automatic test_empty_ready();
        for (int k = 0; k < 3; k++) begin
            drive(0, '0, '0, 1, 0);
            tick();
            n_checks++;
            if (o_Valid !== 1'b0 || o_Count !== '0) begin
                n_errors++;
                $display("FAIL empty_ready[%0d]: valid=%b count=%0d want 0/0", k, o_Valid, o_Count);
            end
        end
        drive(1, 27'h55, 27'h455, 0, 0); tick();
        n_checks++;
        if (o_Pc !== 27'h55 || o_Instruction !== 27'h455 || o_Count !== 3'd1) begin
            n_errors++;
            $display("FAIL empty_then_push: pc=%h instr=%h count=%0d want 55/455/1", o_Pc, o_Instruction, o_Count);
        end
        drive(0, '0, '0, 1, 0); tick();
        drive(0, '0, '0, 0, 0);
        seen.delete();
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_pc;
        logic [DW-1:0] exp_ins;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, DW'($urandom()), DW'($urandom()),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            tick();
            exp_pc  = (mq.size() != 0) ? mq[0].pc : '0;
            exp_ins = (mq.size() != 0) ? mq[0].instr : '0;
            n_checks++;
            if (o_Count !== (PW + 1)'(mq.size()) || o_Valid !== (mq.size() != 0) ||
                o_Freeze !== (mq.size() == DEPTH) || o_Pc !== exp_pc || o_Instruction !== exp_ins) begin
                n_errors++;
                $display("FAIL random[%0d]: count=%0d valid=%b freeze=%b pc=%h instr=%h want %0d/%b/%b/%h/%h",
                         c, o_Count, o_Valid, o_Freeze, o_Pc, o_Instruction, mq.size(),
                         mq.size() != 0, mq.size() == DEPTH, exp_pc, exp_ins);
            end
        end
        drive(0, '0, '0, 0, 0);
        seen.delete();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        test_reset();
        test_reset_mid();
        test_fill_full();
        test_drain_wrap();
        test_push_pop();
        test_flush_full();
        test_back_to_back_flush();
        test_empty_ready();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
